// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with a per-transfer watchdog in front of one shared slave.
// One cycle of arbitration latency from IDLE, none on handover; masters stall via the slave's ack.
module wb_rr_arbiter #(
    parameter int unsigned timeout = 1023
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [15:0] TMO = 16'(timeout);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        gnt0, gnt1, wd_hit;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                    last_d  = m1_cyc_i ? 1'b1 : last_q;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                    last_d  = m0_cyc_i ? 1'b0 : last_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (gnt0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
        end else if (gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
        end
    end

    // A slave ack arriving on the very cycle the limit is reached still completes the transfer.
    assign wd_hit = (TMO != 16'd0) && (wd_cnt_q == TMO) && s_stb_o && !s_ack_i;

    always_comb begin
        if (wd_hit)
            wd_cnt_d = '0;
        else if (s_stb_o && !s_ack_i && !s_err_i)
            wd_cnt_d = wd_cnt_q + 16'd1;
        else
            wd_cnt_d = '0;
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = gnt0 & s_ack_i;
    assign m1_ack_o = gnt1 & s_ack_i;
    assign m0_err_o = gnt0 & (s_err_i | wd_hit);
    assign m1_err_o = gnt1 & (s_err_i | wd_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule
